fc_bp_err_seq: RTL
==================

Name: fc_bp_err_seq

Overview:
Fully-connected output-layer sequencer for the FP/BP training flow.
- Once the conv forward pass completes, it loads the flattened feature vector and runs the FC multiply-accumulate against a weight ROM.
- It streams one output-error value per class, then pulses bp_fc_complete, which starts the phase FSM's BP state.
- It sits between the conv-stage output and the FP/BP phase FSM.

Parameters:
N_IN, 10, number of FC inputs (feature vector length)
N_OUT, 4, number of FC outputs (classes)
DW, 8, signed feature/weight width
FRAC, 6, fractional bits of feature/weight/output fixed point (1.0 = 1<<FRAC)
ACC_W, 20, signed accumulator width
AW, 6, weight address width; must be at least ceil(log2(N_IN*N_OUT))

Ports:
clk  in  1  clock; all logic on rising edge
fsm_rst  in  1  synchronous active-high reset
start  in  1  level; sampled only in IDLE (driven by FP_C_complete)
label  in  4  target class index, captured when start is accepted
feat_valid  in  1  feature stream valid
feat_ready  out  1  feature stream ready
feat_data  in  DW  signed feature
w_addr  out  AW  weight ROM address = o*N_IN + i
w_rd_en  out  1  weight read strobe
w_rdata  in  DW  signed weight, valid the cycle after w_rd_en
err_valid  out  1  one-cycle strobe per class
err_idx  out  4  class index of err_data
err_data  out  DW+1  signed error = fc_out - target
busy  out  1  high in every state except IDLE
bp_fc_complete  out  1  one-cycle pulse at end of sequence

Behaviour:
- States: IDLE, LOAD, MAC, ERR, DONE.
- fsm_rst=1 on a rising edge forces:
  - state IDLE;
  - feat_ready, w_rd_en, err_valid, busy, bp_fc_complete = 0;
  - w_addr, err_idx, err_data = 0;
  - all counters and the accumulator = 0.
  - This applies in any state, including mid-LOAD or mid-MAC. The feature buffer is not cleared.
- IDLE:
  - start=1 -> LOAD, capturing label; load counter cleared.
  - start is ignored in all other states.
- LOAD:
  - feat_ready=1.
  - Each feat_valid & feat_ready cycle writes feat_data to x[load_cnt] and increments load_cnt.
  - Gaps in feat_valid stall the count.
  - When the N_IN-th beat is accepted -> MAC with o=0, i=0, acc=0. feat_ready is 0 from the next cycle.
- MAC (per output o), exactly N_IN+1 cycles:
  - Cycle k=0..N_IN-1: w_rd_en=1, w_addr=o*N_IN+k.
  - Cycle k=1..N_IN: acc <= acc + sext(x[k-1]*w_rdata). The 2*DW-bit signed product is sign-extended to ACC_W.
  - The accumulator wraps at ACC_W; no overflow detection.
  - After cycle k=N_IN -> ERR.
- ERR, 1 cycle:
  - err_valid=1, err_idx=o.
  - fc_out = acc >>> FRAC (arithmetic shift), saturated to [-2^(DW-1), 2^(DW-1)-1].
  - target = (1<<FRAC) if o==label, else 0. A label >= N_OUT gives target 0 for all classes.
  - err_data = fc_out - target, computed at DW+1 bits; it never overflows.
  - Then acc=0, o=o+1. Go to MAC if o<N_OUT-1, else DONE.
- DONE, 1 cycle:
  - bp_fc_complete=1, busy=1.
  - -> IDLE unconditionally. A start high on that same cycle is not seen until IDLE.
- err_* outputs are registered with the ERR state and held outside ERR. Only err_valid qualifies them.
- Timing with feat_valid held high (start accepted in cycle 0):
  - LOAD: cycles 1..N_IN.
  - MAC/ERR: next N_OUT*(N_IN+2) cycles.
  - bp_fc_complete: cycle N_IN + N_OUT*(N_IN+2) + 1, which is 59 at the defaults.
- A new sequence always starts from a fresh LOAD; features are never reused.

Test Plan:
1. Reset -> fsm_rst held 2 cycles with start=1 -> all outputs 0, state IDLE, no feat_ready; release reset with start=1 -> feat_ready=1 on the next cycle.
2. Nominal run (defaults) -> all features 64, all weights 1, label=0, continuous feat_valid:
   - 4 err_valid strobes: idx0 err=-54 (fc_out 10 - 64), idx1..3 err=10;
   - bp_fc_complete exactly at cycle 59 after start accepted; busy high cycles 1..59.
3. Stalled load -> feat_valid asserted only every other cycle -> identical err values; bp_fc_complete delayed by exactly 10 cycles (cycle 69).
4. Saturation -> features 127, weights 127:
   - label=2: fc_out saturates to 127; err idx2=63, others 127.
   - features -128, weights 127, label=1: fc_out saturates to -128; err idx1=-192, others -128.
5. Reset mid-operation -> fsm_rst asserted on 3rd ERR strobe's cycle -> next cycle all outputs 0, no further err_valid or bp_fc_complete; a subsequent start runs a full correct 59-cycle sequence.
6. Protocol corners:
   - start pulses during LOAD/MAC/DONE are ignored;
   - label=7 gives err = fc_out for all 4 classes;
   - w_addr sequence is 0..9, 10..19, 20..29, 30..39, each with w_rd_en;
   - bp_fc_complete is exactly one cycle wide.

Source files
------------

// File: rtl/fc_bp_err_seq.sv
// FC output-layer sequencer: buffers the flattened feature vector, runs one MAC pass
// per class against an external weight ROM, then streams per-class output errors.
module fc_bp_err_seq #(
   parameter int N_IN  = 10,
   parameter int N_OUT = 4,
   parameter int DW    = 8,
   parameter int FRAC  = 6,
   parameter int ACC_W = 20,
   parameter int AW    = 6
) (
   input  logic                 clk,
   input  logic                 fsm_rst,
   input  logic                 start,
   input  logic [3:0]           label,
   input  logic                 feat_valid,
   output logic                 feat_ready,
   input  logic signed [DW-1:0] feat_data,
   output logic [AW-1:0]        w_addr,
   output logic                 w_rd_en,
   input  logic signed [DW-1:0] w_rdata,
   output logic                 err_valid,
   output logic [3:0]           err_idx,
   output logic signed [DW:0]   err_data,
   output logic                 busy,
   output logic                 bp_fc_complete
);

   localparam int CW = $clog2(N_IN + 1);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LOAD = 3'd1;
   localparam logic [2:0] S_MAC  = 3'd2;
   localparam logic [2:0] S_ERR  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   localparam logic [CW-1:0] K_LAST    = CW'(N_IN);
   localparam logic [CW-1:0] LOAD_LAST = CW'(N_IN - 1);
   localparam logic [3:0]    O_LAST    = 4'(N_OUT - 1);
   localparam logic [AW-1:0] O_STRIDE  = AW'(N_IN);
   localparam logic [DW:0]   TGT_ONE   = {{(DW - FRAC){1'b0}}, 1'b1, {FRAC{1'b0}}};

   logic [2:0]               r_state;
   logic [CW-1:0]            r_load_cnt;
   logic [CW-1:0]            r_k;
   logic [3:0]               r_o;
   logic [AW-1:0]            r_base;
   logic signed [ACC_W-1:0]  r_acc;
   logic [3:0]               r_label;
   logic                     r_err_valid;
   logic [3:0]               r_err_idx;
   logic signed [DW:0]       r_err_data;

   logic signed [DW-1:0]     r_x [N_IN];
   logic signed [DW-1:0]     r_x_rd;

   logic signed [2*DW-1:0]   w_prod;
   logic signed [ACC_W-1:0]  w_acc_sum;
   logic signed [ACC_W-1:0]  w_sh;
   logic [ACC_W-DW:0]        w_hi;
   logic                     w_fits;
   logic [DW-1:0]            w_fc_out;
   logic [DW:0]              w_target;
   logic signed [DW:0]       w_err;

   // Feature buffer read is registered one cycle ahead so it lines up with w_rdata.
   assign w_prod    = r_x_rd * w_rdata;
   assign w_acc_sum = r_acc + {{(ACC_W - 2*DW){w_prod[2*DW-1]}}, w_prod};
   assign w_sh      = w_acc_sum >>> FRAC;
   assign w_hi      = w_sh[ACC_W-1:DW-1];
   assign w_fits    = (&w_hi) | ~(|w_hi);
   assign w_fc_out  = w_fits ? w_sh[DW-1:0]
                    : (w_sh[ACC_W-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}});
   assign w_target  = (r_label == r_o) ? TGT_ONE : '0;
   assign w_err     = {w_fc_out[DW-1], w_fc_out} - w_target;

   assign feat_ready     = (r_state == S_LOAD);
   assign busy           = (r_state != S_IDLE);
   assign bp_fc_complete = (r_state == S_DONE);
   assign w_rd_en        = (r_state == S_MAC) && (r_k != K_LAST);
   assign w_addr         = w_rd_en ? (r_base + AW'(r_k)) : '0;
   assign err_valid      = r_err_valid;
   assign err_idx        = r_err_idx;
   assign err_data       = r_err_data;

   // Feature storage: not cleared by reset, every sequence reloads it.
   always_ff @(posedge clk) begin
      if (!fsm_rst && r_state == S_LOAD && feat_valid) begin
         r_x[r_load_cnt] <= feat_data;
      end
      if (r_state == S_MAC && r_k != K_LAST) begin
         r_x_rd <= r_x[r_k];
      end
   end

   always_ff @(posedge clk) begin
      if (fsm_rst) begin
         r_state     <= S_IDLE;
         r_load_cnt  <= '0;
         r_k         <= '0;
         r_o         <= '0;
         r_base      <= '0;
         r_acc       <= '0;
         r_label     <= '0;
         r_err_valid <= 1'b0;
         r_err_idx   <= '0;
         r_err_data  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state    <= S_LOAD;
                  r_label    <= label;
                  r_load_cnt <= '0;
               end
            end
            S_LOAD: begin
               if (feat_valid) begin
                  if (r_load_cnt == LOAD_LAST) begin
                     r_state    <= S_MAC;
                     r_load_cnt <= '0;
                     r_o        <= '0;
                     r_k        <= '0;
                     r_base     <= '0;
                     r_acc      <= '0;
                  end else begin
                     r_load_cnt <= r_load_cnt + 1'b1;
                  end
               end
            end
            S_MAC: begin
               if (r_k != '0) begin
                  r_acc <= w_acc_sum;
               end
               if (r_k == K_LAST) begin
                  // Final product lands this edge, so the error is formed from the sum.
                  r_state     <= S_ERR;
                  r_k         <= '0;
                  r_err_valid <= 1'b1;
                  r_err_idx   <= r_o;
                  r_err_data  <= w_err;
               end else begin
                  r_k <= r_k + 1'b1;
               end
            end
            S_ERR: begin
               r_err_valid <= 1'b0;
               r_acc       <= '0;
               r_k         <= '0;
               r_o         <= r_o + 1'b1;
               r_base      <= r_base + O_STRIDE;
               r_state     <= (r_o == O_LAST) ? S_DONE : S_MAC;
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
